// File: rtl/parallel_to_serial_pkg.sv
// Shared types and sizing helpers for the parallel_to_serial block.
package parallel_to_serial_pkg;

  typedef enum logic {IDLE, SHIFT} p2s_state_t;

  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/p2s_hold_reg.sv
// One-entry valid/ready holding buffer; the owner never pushes while full.
module p2s_hold_reg #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [width-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic [width-1:0] data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (push) begin
      valid <= 1'b1;
      data  <= push_data;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/parallel_to_serial.sv
// Word-to-bit serialiser, LSB first, valid/ready on both sides.
// Define PARALLEL_TO_SERIAL_SKID_EN for a one-word holding register (gapless streaming).
module parallel_to_serial
  import parallel_to_serial_pkg::*;
#(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             parallel_valid,
  input  logic [width-1:0] parallel_data,
  output logic             parallel_ready,
  output logic             serial_valid,
  output logic             serial_data,
  input  logic             serial_ready,
  output logic             busy
);

  localparam int CW = cnt_width(width);

  p2s_state_t       state, state_nxt;
  logic [width-1:0] shift_reg;
  logic [CW-1:0]    cnt;
  logic             xfer, last, load, direct, promote, hold_valid;
  logic [width-1:0] hold_data;

  assign xfer = (state == SHIFT) && serial_ready;
  assign last = xfer && (cnt == CW'(width - 1));
  assign load = parallel_valid && parallel_ready;

`ifdef PARALLEL_TO_SERIAL_SKID_EN
  logic hold_push;

  // A load landing on the last-bit transfer with an empty hold goes straight
  // into the shift register; otherwise loads during SHIFT park in the hold.
  assign parallel_ready = !hold_valid;
  assign direct         = load && ((state == IDLE) || last);
  assign hold_push      = load && !direct;
  assign promote        = hold_valid && (last || (state == IDLE));

  p2s_hold_reg #(.width(width)) u_hold (
    .clk       (clk),
    .rst       (rst),
    .push      (hold_push),
    .push_data (parallel_data),
    .pop       (promote),
    .valid     (hold_valid),
    .data      (hold_data)
  );
`else
  assign parallel_ready = (state == IDLE);
  assign direct         = load;
  assign promote        = 1'b0;
  assign hold_valid     = 1'b0;
  assign hold_data      = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (direct || promote) state_nxt = SHIFT;
      SHIFT:   if (last && !direct && !promote) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= '0;
      cnt       <= '0;
    end else if (direct) begin
      shift_reg <= parallel_data;
      cnt       <= '0;
    end else if (promote) begin
      shift_reg <= hold_data;
      cnt       <= '0;
    end else if (xfer) begin
      shift_reg <= shift_reg >> 1;
      if (!last) cnt <= cnt + CW'(1);
    end
  end

  assign serial_valid = (state == SHIFT);
  assign serial_data  = shift_reg[0];
  assign busy         = (state == SHIFT) || hold_valid;

endmodule

// File: doc/parallel_to_serial.md
Name: parallel_to_serial

Overview:
- Converts a `width`-bit word, taken with a valid/ready handshake, into a one-bit-per-transfer serial stream with its own valid/ready handshake.
- Sits directly upstream of serial_to_parallel and feeds its serial_valid/serial_data inputs.
- Bits leave LSB first, so serial_to_parallel (which shifts new bits in at the MSB) rebuilds the original word unchanged.

Parameters:
- width, 8: bits per parallel word; legal range >= 2.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- parallel_valid  input  1  parallel_data holds a word to load.
- parallel_data  input  width  word to serialise.
- parallel_ready  output  1  block accepts a word this cycle; a word loads when parallel_valid && parallel_ready.
- serial_valid  output  1  serial_data holds a valid bit.
- serial_data  output  1  current bit, LSB of the word first.
- serial_ready  input  1  downstream takes the bit; a bit transfers when serial_valid && serial_ready.
- busy  output  1  a word is being shifted or held; low only when fully idle.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: serial_valid=0, serial_data=0, busy=0, parallel_ready=1. The bit counter, shift register, state and holding register are all cleared.
- Reset mid-word: the partial word is dropped silently. No bits are emitted after reset.
- State machine:
  - IDLE: parallel_ready=1, serial_valid=0. On a load, copy parallel_data into the shift register, clear the counter, go to SHIFT.
  - SHIFT: serial_valid=1, serial_data = shift_reg[0].
    - On each transfer, shift right by one and increment the counter.
    - On the transfer where counter==width-1 (last bit), go to IDLE. The word takes exactly width transfers.
- Latency: the first bit appears on serial_valid in the cycle after the load.
- Backpressure: while serial_ready=0, serial_valid, serial_data, the counter and the shift register all hold.
- serial_valid never deasserts mid-word except on reset.
- parallel_ready depends only on registered state. There is no combinational path from serial_ready or parallel_valid to parallel_ready.
- Base throughput: one idle cycle between words (width+1 cycles per word when serial_ready=1).
- Counter width: $clog2(width). Wrap to 0 only via reload; never free-running.
- parallel_data is ignored when parallel_valid=0 or parallel_ready=0.
- busy = (state==SHIFT) or holding register valid.

Optional Feature:
- Macro: PARALLEL_TO_SERIAL_SKID_EN.
- Defined:
  - Adds a one-word holding register with a hold_valid flag.
  - parallel_ready = !hold_valid. Words are accepted while in SHIFT.
  - On the last-bit transfer with hold_valid=1, the held word moves into the shift register in the same cycle and the state stays SHIFT. Throughput is width cycles per word, with no gap.
  - A load on the same cycle the held word is promoted is refused, because parallel_ready is already low that cycle.
  - Load while IDLE and hold empty goes straight to the shift register, as in the base design.
- Undefined: base behaviour above; hold logic is absent.

Decomposition:
- Package parallel_to_serial_pkg:
  - typedef enum logic {IDLE, SHIFT} p2s_state_t.
  - Function for counter width ($clog2(width)).
- Natural sub-module: p2s_hold_reg, a one-entry valid/ready buffer used only under PARALLEL_TO_SERIAL_SKID_EN.

Test Plan:
- Reset then single word: width=8, load 8'hA5, serial_ready=1 → bits 1,0,1,0,0,1,0,1 on cycles 1..8; serial_valid low on cycle 9; parallel_ready back to 1.
- Backpressure: load 8'h3C; drop serial_ready for 3 cycles after bit 2 → serial_data holds bit 2 value (1) stable; 8 transfers total; sequence 0,0,1,1,1,1,0,0.
- Loopback: chain into serial_to_parallel (width=8); send 8'h00, 8'hFF, 8'h81 → receiver outputs those exact words with parallel_valid one pulse each.
- Reset mid-word: assert rst after 4 bits of 8'hF0 → next cycle serial_valid=0, busy=0, parallel_ready=1; next word 8'h0F serialises cleanly as 1,1,1,1,0,0,0,0.
- Back-to-back, base build: parallel_valid held high with 8'h55 then 8'hAA → one idle cycle between words; parallel_ready low throughout SHIFT.
- Back-to-back, with PARALLEL_TO_SERIAL_SKID_EN: same stimulus → 16 consecutive cycles of serial_valid=1, no gap; parallel_ready low only while hold full.
